// File: rtl/add_float_pkg.sv
// add_float_pkg: shared definitions for the bit-serial floating-point adder.
//   state_t        - controller state encoding
//   calc_w()       - word width from exponent/mantissa split
//   calc_bias()    - exponent bias for a given exponent width
//   exp_saturated()- true when a (widened) exponent reaches the all-ones code
package add_float_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD_A = 4'd1,
    S_LOAD_B = 4'd2,
    S_UNPACK = 4'd3,
    S_ALIGN  = 4'd4,
    S_ADD    = 4'd5,
    S_NORM   = 4'd6,
    S_PACK   = 4'd7,
    S_OUT    = 4'd8,
    S_DONE   = 4'd9
  } state_t;

  function automatic int calc_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int calc_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Exponent is carried one bit wider than the field so that a normalising
  // carry past the largest finite exponent is still visible here.
  function automatic logic exp_saturated(input logic [12:0] e, input int exp_w);
    return e >= 13'((1 << exp_w) - 1);
  endfunction

endpackage

// File: rtl/float_shreg.sv
// float_shreg: N-bit shift register, MSB-first.
//   clk, reset     - clock, asynchronous active-low reset
//   i_shift        - shift left one place, i_serial entering at bit 0
//   i_load         - parallel load of i_d (has priority over shift)
//   o_serial       - current MSB
//   o_q            - parallel contents
module float_shreg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_shift,
  input  logic         i_load,
  input  logic         i_serial,
  input  logic [N-1:0] i_d,
  output logic         o_serial,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_q <= '0;
    else if (i_load)  r_q <= i_d;
    else if (i_shift) r_q <= {r_q[N-2:0], i_serial};
  end

  assign o_serial = r_q[N-1];
  assign o_q      = r_q;

endmodule

// File: rtl/add_float_p.sv
// add_float_p: bit-serial floating-point adder/subtractor.
//   clk, reset - clock, asynchronous active-low reset
//   go         - active-low start, sampled in IDLE; sub latched with it
//   inpab      - serial operands, A then B, MSB first
//   shift      - high while out_c carries a result bit (W cycles)
//   out_c      - serial result, MSB first
//   over/under - exponent overflow / underflow of the last result
//   done       - one-cycle pulse after the last result bit
module add_float_p
  import add_float_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic sub,
  input  logic inpab,
  output logic shift,
  output logic out_c,
  output logic over,
  output logic under,
  output logic done
);

  localparam int W  = calc_w(EXP_W, MAN_W);
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [EXP_W:0] EXP_ONE  = (EXP_W + 1)'(1);

  state_t              r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic                r_sub, r_sign, r_eff_add, r_over, r_under;
  logic [EXP_W:0]      r_exp;
  logic [MAN_W:0]      r_big_sig, r_sml_sig;
  logic [MAN_W+1:0]    r_sum;

  logic [2*W-1:0]      w_ops;
  logic [W-1:0]        w_a, w_b, w_res_word, w_res_q;
  logic                w_ops_so, w_res_msb;
  logic [EXP_W-1:0]    w_ea, w_eb, w_big_e, w_sml_e, w_diff;
  logic [MAN_W:0]      w_a_sig, w_b_sig;
  logic                w_a_neg, w_b_neg, w_a_big, w_far, w_ovf;
  logic [MAN_W+1:0]    w_sum;

  float_shreg #(.N(2 * W)) u_ops (
    .clk      (clk),
    .reset    (reset),
    .i_shift  (r_state == S_LOAD_A || r_state == S_LOAD_B),
    .i_load   (1'b0),
    .i_serial (inpab),
    .i_d      ('0),
    .o_serial (w_ops_so),
    .o_q      (w_ops)
  );

  float_shreg #(.N(W)) u_res (
    .clk      (clk),
    .reset    (reset),
    .i_shift  (r_state == S_OUT),
    .i_load   (r_state == S_PACK),
    .i_serial (1'b0),
    .i_d      (w_res_word),
    .o_serial (w_res_msb),
    .o_q      (w_res_q)
  );

  logic w_unused;
  assign w_unused = ^{w_ops_so, w_res_q};

  // Unpack: zero exponent flushes the significand (and hidden bit) to zero.
  assign w_a     = w_ops[2*W-1:W];
  assign w_b     = w_ops[W-1:0];
  assign w_ea    = w_a[W-2:MAN_W];
  assign w_eb    = w_b[W-2:MAN_W];
  assign w_a_sig = (w_ea != '0) ? {1'b1, w_a[MAN_W-1:0]} : '0;
  assign w_b_sig = (w_eb != '0) ? {1'b1, w_b[MAN_W-1:0]} : '0;
  assign w_a_neg = w_a[W-1];
  assign w_b_neg = w_b[W-1] ^ r_sub;
  assign w_a_big = {w_ea, w_a_sig} >= {w_eb, w_b_sig};
  assign w_big_e = w_a_big ? w_ea : w_eb;
  assign w_sml_e = w_a_big ? w_eb : w_ea;
  assign w_diff  = w_big_e - w_sml_e;
  assign w_far   = int'(w_diff) > MAN_W;

  assign w_sum = r_eff_add ? ({1'b0, r_big_sig} + {1'b0, r_sml_sig})
                           : ({1'b0, r_big_sig} - {1'b0, r_sml_sig});

  // Zero and underflow results arrive here with exponent and sum cleared.
  assign w_ovf      = exp_saturated(13'(r_exp), EXP_W);
  assign w_res_word = w_ovf ? {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                            : {r_sign, r_exp[EXP_W-1:0], r_sum[MAN_W-1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!go) w_next = S_LOAD_A;
      S_LOAD_A: if (r_cnt == CNT_LAST) w_next = S_LOAD_B;
      S_LOAD_B: if (r_cnt == CNT_LAST) w_next = S_UNPACK;
      S_UNPACK: w_next = (w_far || w_diff == '0) ? S_ADD : S_ALIGN;
      S_ALIGN:  if (r_cnt == CNT_ONE) w_next = S_ADD;
      S_ADD: begin
        if (w_sum == '0)                          w_next = S_PACK;
        else if (w_sum[MAN_W+1] || !w_sum[MAN_W]) w_next = S_NORM;
        else                                      w_next = S_PACK;
      end
      S_NORM: begin
        if (r_sum[MAN_W+1] || r_sum[MAN_W])         w_next = S_PACK;
        else if (r_exp <= EXP_ONE || r_sum[MAN_W-1]) w_next = S_PACK;
      end
      S_PACK:   w_next = S_OUT;
      S_OUT:    if (r_cnt == CNT_LAST) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    shift = (r_state == S_OUT);
    out_c = (r_state == S_OUT) & w_res_msb;
    done  = (r_state == S_DONE);
    over  = r_over;
    under = r_under;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_sub     <= 1'b0;
      r_sign    <= 1'b0;
      r_eff_add <= 1'b0;
      r_over    <= 1'b0;
      r_under   <= 1'b0;
      r_exp     <= '0;
      r_big_sig <= '0;
      r_sml_sig <= '0;
      r_sum     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (!go) begin
          r_cnt   <= '0;
          r_sub   <= sub;
          r_over  <= 1'b0;
          r_under <= 1'b0;
        end
        S_LOAD_A, S_LOAD_B: r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;
        S_UNPACK: begin
          r_big_sig <= w_a_big ? w_a_sig : w_b_sig;
          r_sml_sig <= w_far ? '0 : (w_a_big ? w_b_sig : w_a_sig);
          r_sign    <= w_a_big ? w_a_neg : w_b_neg;
          r_eff_add <= (w_a_neg == w_b_neg);
          r_exp     <= {1'b0, w_big_e};
          r_cnt     <= CW'(w_diff);
        end
        S_ALIGN: begin
          r_sml_sig <= r_sml_sig >> 1;
          r_cnt     <= r_cnt - CNT_ONE;
        end
        S_ADD: begin
          r_sum <= w_sum;
          if (w_sum == '0) begin
            r_sign <= 1'b0;
            r_exp  <= '0;
          end
        end
        S_NORM: begin
          if (r_sum[MAN_W+1]) begin
            r_sum <= r_sum >> 1;
            r_exp <= r_exp + EXP_ONE;
          end else if (!r_sum[MAN_W]) begin
            if (r_exp <= EXP_ONE) begin
              // A further left shift would need exponent 0: flush to signed zero.
              r_under <= 1'b1;
              r_exp   <= '0;
              r_sum   <= '0;
            end else begin
              r_sum <= r_sum << 1;
              r_exp <= r_exp - EXP_ONE;
            end
          end
        end
        S_PACK: begin
          r_over <= w_ovf;
          r_cnt  <= '0;
        end
        S_OUT:  r_cnt <= r_cnt + CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule
